// File: rtl/dw01_slice_pack.sv
// Slice-insertion register: writes MUX_width-bit slices into an A_width-bit word, then hands the word out.
// Define DW_SLICE_PACK_CLR_EN to zero the word on each output handshake.
module dw01_slice_pack #(
  parameter int unsigned A_width   = 8,
  parameter int unsigned SEL_width = 2,
  parameter int unsigned MUX_width = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 init,
  input  logic                 auto_inc,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SEL_width-1:0] SEL,
  input  logic [MUX_width-1:0] DIN,
  input  logic                 commit,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [A_width-1:0]   A,
  output logic [SEL_width-1:0] ptr,
  output logic                 err
);

  localparam int unsigned NSLICE = (A_width + MUX_width - 1) / MUX_width;
  localparam logic [SEL_width:0]   NSLICE_W = (SEL_width+1)'(NSLICE);
  localparam logic [SEL_width-1:0] LAST_IDX = SEL_width'(NSLICE - 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                 state_q, state_n;
  logic [A_width-1:0]     a_n;
  logic [SEL_width-1:0]   ptr_n;
  logic                   err_n;
  logic [SEL_width-1:0]   idx;
  logic                   in_range;
  logic [A_width-1:0]     mask;
  logic [A_width-1:0]     a_wr;
  int unsigned            shamt;

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == HOLD);

  // Slice merge: bits shifted past A_width fall off, which drops the tail of a partial last slice.
  always_comb begin
    idx      = auto_inc ? ptr : SEL;
    in_range = ({1'b0, idx} < NSLICE_W);
    shamt    = 32'(idx) * MUX_width;
    mask     = A_width'({MUX_width{1'b1}}) << shamt;
    a_wr     = (A & ~mask) | (A_width'(DIN) << shamt);
  end

  // Next-state and output decode.
  always_comb begin
    state_n = state_q;
    a_n     = A;
    ptr_n   = ptr;
    err_n   = 1'b0;
    if (init) begin
      state_n = FILL;
      a_n     = '0;
      ptr_n   = '0;
    end else begin
      case (state_q)
        FILL: begin
          if (in_valid) begin
            if (!in_range) begin
              err_n = 1'b1;
            end else begin
              a_n = a_wr;
              if (auto_inc) begin
                if (idx == LAST_IDX) begin
                  ptr_n   = '0;
                  state_n = HOLD;
                end else begin
                  ptr_n = ptr + SEL_width'(1);
                end
              end else if (commit) begin
                state_n = HOLD;
              end
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_n = FILL;
`ifdef DW_SLICE_PACK_CLR_EN
            a_n = '0;
`else
            a_n = A;
`endif
          end
        end
        default: state_n = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      A       <= '0;
      ptr     <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_n;
      A       <= a_n;
      ptr     <= ptr_n;
      err     <= err_n;
    end
  end

endmodule

// File: tb/tb_dw01_slice_pack.sv
// Bench for dw01_slice_pack: NSLICE=3 instance (auto/oor/reset/init) and NSLICE=4 instance (explicit).
module tb_dw01_slice_pack;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 8-bit word, 3-bit slices
  logic       init, auto_inc, in_valid, commit, out_ready;
  logic [1:0] sel;
  logic [2:0] din;
  logic       in_ready, out_valid, err;
  logic [7:0] a;
  logic [1:0] ptr;

  // 8-bit word, 2-bit slices
  logic       init2, auto_inc2, in_valid2, commit2, out_ready2;
  logic [1:0] sel2;
  logic [1:0] din2;
  logic       in_ready2, out_valid2, err2;
  logic [7:0] a2;
  logic [1:0] ptr2;

  dw01_slice_pack #(.A_width(8), .SEL_width(2), .MUX_width(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .init(init), .auto_inc(auto_inc),
    .in_valid(in_valid), .in_ready(in_ready), .SEL(sel), .DIN(din),
    .commit(commit), .out_valid(out_valid), .out_ready(out_ready),
    .A(a), .ptr(ptr), .err(err)
  );

  dw01_slice_pack #(.A_width(8), .SEL_width(2), .MUX_width(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .init(init2), .auto_inc(auto_inc2),
    .in_valid(in_valid2), .in_ready(in_ready2), .SEL(sel2), .DIN(din2),
    .commit(commit2), .out_valid(out_valid2), .out_ready(out_ready2),
    .A(a2), .ptr(ptr2), .err(err2)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  q[$];
  logic [7:0]  q2[$];
  logic [7:0]  m_a = '0;
  logic [1:0]  m_ptr = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One beat on the 3-bit-slice instance; called at a negedge, returns at the next one.
  task automatic beat(input logic [2:0] d, input logic [1:0] s, input logic au,
                      input logic cm, input logic ini);
    int unsigned ix;
    logic done, oor;
    ix   = au ? int'(m_ptr) : int'(s);
    done = 1'b0;
    oor  = 1'b0;
    if (ini) begin
      m_a   = '0;
      m_ptr = '0;
    end else if (ix >= 3) begin
      oor = 1'b1;
    end else begin
      for (int i = 0; i < 3; i++)
        if (ix * 3 + i < 8) m_a[ix*3+i] = d[i];
      if (au) begin
        if (ix == 2) begin m_ptr = '0; done = 1'b1; end
        else m_ptr = m_ptr + 2'd1;
      end else if (cm) begin
        done = 1'b1;
      end
    end
    if (done) q.push_back(m_a);
    din = d; sel = s; auto_inc = au; commit = cm; init = ini; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; commit = 1'b0; init = 1'b0;
    check("beat_a", a, m_a);
    check("beat_ptr", ptr, m_ptr);
    check("beat_err", err, oor);
    check("beat_out_valid", out_valid, done);
  endtask

  // Wait for a word, compare it against the scoreboard, then complete the handshake.
  task automatic take();
    int n = 0;
    logic [7:0] exp;
    in_valid = 1'b0;
    while (!out_valid && n < 10) begin @(negedge clk); n++; end
    check("take_timeout", out_valid, 1);
    check("sb_pending", q.size() != 0, 1);
    if (q.size() != 0) begin
      exp = q.pop_front();
      check("word", a, exp);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
`ifdef DW_SLICE_PACK_CLR_EN
    m_a = '0;
`endif
    check("take_in_ready", in_ready, 1);
    check("take_out_valid", out_valid, 0);
    check("take_a", a, m_a);
  endtask

  initial begin
    rst_n = 1'b0;
    {init, auto_inc, in_valid, commit, out_ready, sel, din} = '0;
    {init2, auto_inc2, in_valid2, commit2, out_ready2, sel2, din2} = '0;
    #2;
    check("rst_a", a, 0);
    check("rst_ptr", ptr, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_err", err, 0);
    check("rst_a2", a2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Explicit mode on 2-bit slices: slice 3 <- 10, slice 0 <- 01 with commit
    sel2 = 2'd3; din2 = 2'b10; in_valid2 = 1'b1;
    @(negedge clk);
    check("exp_first_ptr", ptr2, 0);
    sel2 = 2'd0; din2 = 2'b01; commit2 = 1'b1;
    q2.push_back(8'h81);
    @(negedge clk);
    commit2 = 1'b0; sel2 = 2'd1; din2 = 2'b11;
    check("exp_a", a2, 8'h81);
    check("exp_out_valid", out_valid2, 1);
    check("exp_in_ready", in_ready2, 0);
    repeat (2) begin
      @(negedge clk);
      check("exp_hold_in_ready", in_ready2, 0);
      check("exp_hold_a", a2, 8'h81);
    end
    in_valid2 = 1'b0;
    check("exp_sb_pending", q2.size() != 0, 1);
    if (q2.size() != 0) check("exp_word", a2, q2.pop_front());
    out_ready2 = 1'b1;
    @(negedge clk);
    out_ready2 = 1'b0;
    check("exp_back_in_ready", in_ready2, 1);
    check("exp_back_out_valid", out_valid2, 0);

    // Auto mode, top bit of the third slice dropped
    beat(3'b101, 2'd0, 1'b1, 1'b0, 1'b0);
    beat(3'b010, 2'd0, 1'b1, 1'b0, 1'b0);
    beat(3'b111, 2'd0, 1'b1, 1'b0, 1'b0);
    check("auto_d5", a, 8'hD5);
    check("auto_in_ready", in_ready, 0);
    take();

    // Out-of-range explicit index
    beat(3'b111, 2'd3, 1'b0, 1'b0, 1'b0);
    check("oor_in_ready", in_ready, 1);
    @(negedge clk);
    check("oor_err_pulse", err, 0);

    // Random auto words
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 3; k++) beat(3'($urandom), 2'd0, 1'b1, 1'b0, 1'b0);
      take();
    end

    // Mixed modes: auto slice 0, explicit slice 2 with commit, then auto finishes a word
    beat(3'b011, 2'd0, 1'b1, 1'b0, 1'b0);
    beat(3'b100, 2'd2, 1'b0, 1'b1, 1'b0);
    take();
    beat(3'b110, 2'd0, 1'b1, 1'b0, 1'b0);
    beat(3'b001, 2'd0, 1'b1, 1'b0, 1'b0);
    take();

    // Back-pressure in HOLD
    for (int k = 0; k < 3; k++) beat(3'($urandom), 2'd0, 1'b1, 1'b0, 1'b0);
    repeat (5) begin
      in_valid = 1'b1; din = 3'($urandom); auto_inc = 1'b1;
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_a", a, m_a);
    end
    take();

    // Asynchronous reset mid-word
    beat(3'b110, 2'd0, 1'b1, 1'b0, 1'b0);
    beat(3'b011, 2'd0, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_a", a, 0);
    check("arst_ptr", ptr, 0);
    check("arst_in_ready", in_ready, 1);
    m_a = '0; m_ptr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    beat(3'b001, 2'd0, 1'b1, 1'b0, 1'b0);
    check("arst_first_slice", a, 8'h01);
    beat(3'b111, 2'd0, 1'b1, 1'b0, 1'b0);
    beat(3'b010, 2'd0, 1'b1, 1'b0, 1'b0);
    take();

    // init wins over an accepted beat
    beat(3'b110, 2'd0, 1'b1, 1'b0, 1'b0);
    beat(3'b011, 2'd0, 1'b1, 1'b0, 1'b1);
    check("init_in_ready", in_ready, 1);
    beat(3'b111, 2'd3, 1'b0, 1'b0, 1'b1);

    check("sb_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
